// File: rtl/uart_term_pkg.sv
// Shared constants and FSM encoding for the UART line terminal.
package uart_term_pkg;

  localparam int ASC_BEL   = 'h07;
  localparam int ASC_BS    = 'h08;
  localparam int ASC_DEL   = 'h7F;
  localparam int ASC_CR    = 'h0D;
  localparam int ASC_LF    = 'h0A;
  localparam int ASC_SP    = 'h20;
  localparam int ASC_TILDE = 'h7E;

  typedef enum logic [2:0] {
    IDLE,
    PROC,
    ECHO,
    ECHO2,
    DUMP,
    DUMP_CR,
    DUMP_LF
  } term_state_t;

endpackage

// File: rtl/term_line_buf.sv
// Line buffer register file: one write port, an indexed read port and a
// newest-first window of the last DISP_BYTES characters.
module term_line_buf
  import uart_term_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int LINE_DEPTH = 16,
  parameter int DISP_BYTES = 4,
  parameter int LW         = $clog2(LINE_DEPTH + 1),
  parameter int AW         = $clog2(LINE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [DBIT-1:0]            wdata,
  input  logic [AW-1:0]              raddr,
  output logic [DBIT-1:0]            rdata,
  input  logic [LW-1:0]              count,
  output logic [DISP_BYTES*DBIT-1:0] win_bytes,
  output logic [DISP_BYTES-1:0]      win_valid
);

  logic [DBIT-1:0] mem [LINE_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // Window slot i holds the character i positions behind the newest one.
  for (genvar i = 0; i < DISP_BYTES; i++) begin : g_win
    assign win_valid[i] = (count > LW'(i));
    assign win_bytes[i*DBIT +: DBIT] =
      win_valid[i] ? mem[AW'(count - LW'(i + 1))] : '0;
  end

endmodule

// File: rtl/uart_line_terminal.sv
// Line-editing terminal between the UART FIFOs and the hex display: pops rx
// bytes, edits a line buffer, echoes, reports lines on CR and replays on request.
module uart_line_terminal
  import uart_term_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int LINE_DEPTH = 16,
  parameter int DISP_BYTES = 4,
  parameter int LW         = $clog2(LINE_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_empty,
  input  logic [DBIT-1:0]            r_data,
  output logic                       rd_uart,
  input  logic                       tx_full,
  output logic [DBIT-1:0]            w_data,
  output logic                       wr_uart,
  input  logic                       echo_en,
  input  logic                       dump_req,
  output logic                       line_valid,
  output logic [LW-1:0]              line_len,
  output logic [DISP_BYTES*DBIT-1:0] disp_bytes,
  output logic [DISP_BYTES-1:0]      disp_valid,
  output logic                       overflow,
  output logic                       busy
);

  localparam int            AW   = $clog2(LINE_DEPTH);
  localparam logic [LW-1:0] FULL = LW'(LINE_DEPTH);

  term_state_t               state;
  logic [DBIT-1:0]           cur, e0, e1, e2;
  logic [1:0]                e_cnt;
  logic [LW-1:0]             count, idx;
  logic                      dump_pend, after_proc;
  logic                      buf_we;
  logic [DBIT-1:0]           buf_rdata;
  logic [DISP_BYTES*DBIT-1:0] win_bytes;
  logic [DISP_BYTES-1:0]     win_valid;

  function automatic logic is_print(input logic [DBIT-1:0] c);
    return (c >= DBIT'(ASC_SP)) && (c <= DBIT'(ASC_TILDE));
  endfunction

  function automatic logic is_bs(input logic [DBIT-1:0] c);
    return (c == DBIT'(ASC_BS)) || (c == DBIT'(ASC_DEL));
  endfunction

  term_line_buf #(
    .DBIT(DBIT), .LINE_DEPTH(LINE_DEPTH), .DISP_BYTES(DISP_BYTES), .LW(LW), .AW(AW)
  ) u_buf (
    .clk      (clk),
    .we       (buf_we),
    .waddr    (count[AW-1:0]),
    .wdata    (cur),
    .raddr    (idx[AW-1:0]),
    .rdata    (buf_rdata),
    .count    (count),
    .win_bytes(win_bytes),
    .win_valid(win_valid)
  );

  assign buf_we = (state == PROC) && is_print(cur) && (count != FULL);
  assign busy   = (state != IDLE);

  // The cycle right after PROC skips popping so the FIFO's empty flag settles.
  assign rd_uart = !reset && (state == IDLE) && !dump_pend && !after_proc && !rx_empty;

  always_comb begin
    w_data  = '0;
    wr_uart = 1'b0;
    case (state)
      ECHO:    begin w_data = e0;              wr_uart = 1'b1;          end
      ECHO2:   begin w_data = e1;              wr_uart = 1'b1;          end
      DUMP:    begin w_data = buf_rdata;       wr_uart = (idx != count); end
      DUMP_CR: begin w_data = DBIT'(ASC_CR);   wr_uart = 1'b1;          end
      DUMP_LF: begin w_data = DBIT'(ASC_LF);   wr_uart = 1'b1;          end
      default: ;
    endcase
    if (reset || tx_full) wr_uart = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      e_cnt      <= '0;
      dump_pend  <= 1'b0;
      after_proc <= 1'b0;
      line_valid <= 1'b0;
      line_len   <= '0;
      overflow   <= 1'b0;
      disp_bytes <= '0;
      disp_valid <= '0;
    end else begin
      line_valid <= 1'b0;
      after_proc <= (state == PROC);
      disp_bytes <= win_bytes;
      disp_valid <= win_valid;
      if (dump_req) dump_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (dump_pend) begin
            state     <= DUMP;
            idx       <= '0;
            dump_pend <= dump_req;
          end else if (rd_uart) begin
            cur   <= r_data;
            state <= PROC;
          end
        end
        PROC: begin
          state <= IDLE;
          if (is_print(cur)) begin
            e_cnt <= 2'd1;
            if (count != FULL) begin
              count <= count + 1'b1;
              e0    <= cur;
            end else begin
              overflow <= 1'b1;
              e0       <= DBIT'(ASC_BEL);
            end
            if (echo_en) state <= ECHO;
          end else if (is_bs(cur)) begin
            if (count != '0) begin
              count <= count - 1'b1;
              e0    <= DBIT'(ASC_BS);
              e1    <= DBIT'(ASC_SP);
              e2    <= DBIT'(ASC_BS);
              e_cnt <= 2'd3;
              if (echo_en) state <= ECHO;
            end
          end else if (cur == DBIT'(ASC_CR)) begin
            line_valid <= 1'b1;
            line_len   <= count;
            count      <= '0;
            overflow   <= 1'b0;
            e0         <= DBIT'(ASC_CR);
            e1         <= DBIT'(ASC_LF);
            e_cnt      <= 2'd2;
            if (echo_en) state <= ECHO;
          end
        end
        ECHO: begin
          if (!tx_full) begin
            if (e_cnt == 2'd1) state <= IDLE;
            else begin
              state <= ECHO2;
              e_cnt <= e_cnt - 1'b1;
            end
          end
        end
        ECHO2: begin
          if (!tx_full) begin
            if (e_cnt == 2'd1) state <= IDLE;
            else begin
              e1    <= e2;
              e_cnt <= e_cnt - 1'b1;
            end
          end
        end
        DUMP: begin
          if (idx == count) state <= DUMP_CR;
          else if (!tx_full) idx <= idx + 1'b1;
        end
        DUMP_CR: if (!tx_full) state <= DUMP_LF;
        DUMP_LF: if (!tx_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_terminal.sv
// Directed bench for uart_line_terminal: drives a modelled rx FIFO, logs every
// tx push and compares against hand-computed byte sequences.
module tb_uart_line_terminal;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart;
  logic        tx_full = 1'b0;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        echo_en = 1'b0;
  logic        dump_req = 1'b0;
  logic        line_valid;
  logic [4:0]  line_len;
  logic [31:0] disp_bytes;
  logic [3:0]  disp_valid;
  logic        overflow;
  logic        busy;

  uart_line_terminal #(.DBIT(8), .LINE_DEPTH(16), .DISP_BYTES(4)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .echo_en(echo_en),
    .dump_req(dump_req), .line_valid(line_valid), .line_len(line_len),
    .disp_bytes(disp_bytes), .disp_valid(disp_valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_mem [256];
  int         rx_wp = 0;
  int         rd_cnt = 0;
  bit         tx_toggle = 1'b0;
  logic [7:0] tx_log [$];
  logic [7:0] exp_q [$];
  int         base = 0;
  int         cyc = 0;
  int         last_rd = -1000;
  int         min_gap = 1000;
  int         wr_full_cnt = 0;
  int         lv_cnt = 0;
  logic [4:0] last_len = '0;

  // rx FIFO model and tx backpressure, updated just after each active edge
  always @(posedge clk) begin
    #1;
    rx_empty = (rd_cnt == rx_wp);
    r_data   = rx_empty ? 8'h00 : rx_mem[rd_cnt % 256];
    tx_full  = tx_toggle ? ~tx_full : 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rd_uart) begin
      rd_cnt++;
      if (cyc - last_rd < min_gap) min_gap = cyc - last_rd;
      last_rd = cyc;
    end
    if (wr_uart) begin
      tx_log.push_back(w_data);
      if (tx_full) wr_full_cnt++;
    end
    if (line_valid) begin
      lv_cnt++;
      last_len = line_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp % 256] = b;
    rx_wp++;
  endtask

  task automatic mark();
    base = tx_log.size();
  endtask

  task automatic chk_tx(input string tag);
    chk({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
    foreach (exp_q[k])
      if (base + k < tx_log.size())
        chk($sformatf("%s_b%0d", tag, k), 32'(tx_log[base + k]), 32'(exp_q[k]));
  endtask

  task automatic wait_quiet(input string tag);
    int  run;
    bit  done;
    run  = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && rd_cnt == rx_wp) run++;
      else run = 0;
      if (run >= 4) done = 1'b1;
    end
    chk({tag, "_quiet"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_dump();
    @(posedge clk); #1; dump_req = 1'b1;
    @(posedge clk); #1; dump_req = 1'b0;
  endtask

  initial begin
    int lv0, rd0;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr", 32'(wr_uart), 0);
    chk("rst_rd", 32'(rd_uart), 0);
    chk("rst_len", 32'(line_len), 0);
    chk("rst_disp", disp_bytes, 0);
    chk("rst_dvalid", 32'(disp_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Echo "AB" CR
    echo_en = 1'b1;
    mark(); lv0 = lv_cnt;
    push(8'h41); push(8'h42); push(8'h0D);
    wait_quiet("echo");
    exp_q = '{8'h41, 8'h42, 8'h0D, 8'h0A};
    chk_tx("echo");
    chk("echo_lv", 32'(lv_cnt - lv0), 1);
    chk("echo_len", 32'(last_len), 2);
    chk("echo_dvalid", 32'(disp_valid), 0);

    // Backspace
    mark();
    push(8'h58); push(8'h59); push(8'h08);
    wait_quiet("bs");
    exp_q = '{8'h58, 8'h59, 8'h08, 8'h20, 8'h08};
    chk_tx("bs");
    chk("bs_disp", disp_bytes, 32'h0000_0058);
    chk("bs_dvalid", 32'(disp_valid), 4'b0001);
    mark();
    push(8'h7F); push(8'h08);
    wait_quiet("bs0");
    exp_q = '{8'h08, 8'h20, 8'h08};
    chk_tx("bs0");
    chk("bs0_dvalid", 32'(disp_valid), 0);

    // Overflow with 17 chars 'a'..'q'
    mark(); lv0 = lv_cnt;
    exp_q = {};
    for (int i = 0; i < 17; i++) push(8'h61 + 8'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h61 + 8'(i));
    exp_q.push_back(8'h07);
    wait_quiet("ovf");
    chk_tx("ovf");
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_disp", disp_bytes, 32'h6D6E_6F70);
    chk("ovf_dvalid", 32'(disp_valid), 4'hF);
    push(8'h0D);
    wait_quiet("ovf_cr");
    chk("ovf_len", 32'(last_len), 16);
    chk("ovf_clr", 32'(overflow), 0);
    chk("ovf_lv", 32'(lv_cnt - lv0), 1);

    // Dump with tx backpressure toggling every cycle
    echo_en = 1'b0;
    push(8'h48); push(8'h49);
    wait_quiet("hi");
    mark();
    tx_toggle = 1'b1;
    pulse_dump();
    wait_quiet("dump");
    tx_toggle = 1'b0;
    exp_q = '{8'h48, 8'h49, 8'h0D, 8'h0A};
    chk_tx("dump");
    chk("dump_wr_full", 32'(wr_full_cnt), 0);
    @(posedge clk); #1;

    // dump_req during PROC is serviced before the next rx byte
    mark();
    push(8'h4A); push(8'h4B);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rd_uart) found = 1'b1;
    end
    chk("proc_rd_seen", 32'(found), 1);
    pulse_dump();
    wait_quiet("pdump");
    exp_q = '{8'h48, 8'h49, 8'h4A, 8'h0D, 8'h0A};
    chk_tx("pdump");
    push(8'h0D);
    wait_quiet("pdump_cr");
    chk("pdump_len", 32'(last_len), 4);

    // Echo off, OTHER byte ignored
    mark(); rd0 = rd_cnt;
    push(8'h01); push(8'h5A);
    wait_quiet("other");
    exp_q = {};
    chk_tx("other");
    chk("other_rd", 32'(rd_cnt - rd0), 2);
    chk("other_gap", 32'(min_gap >= 3), 1);
    chk("other_dvalid", 32'(disp_valid), 4'b0001);
    chk("other_disp", disp_bytes, 32'h0000_005A);

    // Reset in the middle of a dump
    push(8'h4D); push(8'h4E);
    wait_quiet("zmn");
    mark();
    pulse_dump();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (wr_uart) found = 1'b1;
    end
    chk("rdump_start", 32'(found), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rdump_busy", 32'(busy), 0);
    chk("rdump_wr", 32'(wr_uart), 0);
    chk("rdump_wdata", 32'(w_data), 0);
    chk("rdump_len", 32'(line_len), 0);
    chk("rdump_disp", disp_bytes, 0);
    chk("rdump_dvalid", 32'(disp_valid), 0);
    repeat (10) @(negedge clk);
    exp_q = '{8'h5A};
    chk_tx("rdump");
    chk("rdump_dvalid2", 32'(disp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_line_terminal.md
Name: uart_line_terminal

Overview:
- Line-oriented terminal controller between the UART driver's FIFO interface (rx_empty/r_data/rd_uart, tx_full/w_data/wr_uart) and the seven-segment driver.
- Pops received bytes automatically, with no push-button, and edits them into a line buffer (printable chars and backspace).
- Optionally echoes each byte back, reports completed lines on CR, and replays the buffered line on request.
- Exposes the newest buffered bytes for hex display.

Parameters:
- DBIT, 8, character width in bits.
- LINE_DEPTH, 16, line buffer capacity in characters (>=2).
- DISP_BYTES, 4, number of newest characters exported for display (1..LINE_DEPTH).
- LW, $clog2(LINE_DEPTH+1), width of the line-length fields.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous reset, active-high.
- rx_empty, in, 1: UART rx FIFO empty.
- r_data, in, DBIT: rx FIFO head byte, valid when rx_empty=0.
- rd_uart, out, 1: rx FIFO pop strobe.
- tx_full, in, 1: UART tx FIFO full.
- w_data, out, DBIT: byte to transmit.
- wr_uart, out, 1: tx FIFO push strobe.
- echo_en, in, 1: level; 1 = echo received bytes.
- dump_req, in, 1: single-cycle pulse; replay the buffered line.
- line_valid, out, 1: one-cycle pulse when CR commits a line.
- line_len, out, LW: length of the committed line; held until the next commit.
- disp_bytes, out, DISP_BYTES*DBIT: newest chars, newest in [DBIT-1:0].
- disp_valid, out, DISP_BYTES: bit i set when disp byte i is present.
- overflow, out, 1: sticky; a printable char was dropped because the buffer was full.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State IDLE; count=0; dump_pend=0.
  - All outputs 0.
  - Buffer RAM contents are don't-care.
  - A reset asserted mid-echo or mid-dump aborts the operation, and no further wr_uart follows.
- Character classes:
  - PRINT = 0x20..0x7E.
  - BS = 0x08 or 0x7F.
  - CR = 0x0D.
  - Everything else is OTHER and is ignored: not stored, not echoed.
- States: IDLE, PROC, ECHO, ECHO2, DUMP, DUMP_CR, DUMP_LF.
- IDLE:
  - If dump_pend=1, go to DUMP with idx=0. Dump has priority over rx.
  - Otherwise, if rx_empty=0: rd_uart=1 (combinational, this cycle), latch r_data into cur, go to PROC.
  - rd_uart is asserted only in IDLE and is never high two consecutive cycles.
- dump_req:
  - A pulse in any state sets dump_pend.
  - dump_pend clears on entry to DUMP.
- PROC (1 cycle), by class of cur:
  - PRINT, count<LINE_DEPTH: buf[count]=cur; count++. Echo byte = cur.
  - PRINT, count=LINE_DEPTH: overflow=1; buffer unchanged. Echo byte = 0x07 (BEL).
  - BS, count>0: count--. Echo byte = 0x08, followed by 0x20 and 0x08 (erase sequence, three bytes).
  - BS, count=0: nothing stored, nothing echoed.
  - CR: line_valid=1 for this cycle; line_len=count; count=0; overflow=0. Echo = 0x0D then 0x0A.
  - Next state is ECHO if echo_en=1 and there is an echo byte; otherwise IDLE.
- ECHO / ECHO2 (echo sequence, 1..3 bytes):
  - Each byte is emitted with w_data=byte and wr_uart=1 in a cycle where tx_full=0.
  - When tx_full=1, hold w_data and keep wr_uart=0.
  - Return to IDLE after the last byte.
- DUMP:
  - For idx=0..count-1, emit buf[idx] on each cycle with tx_full=0, then go to DUMP_CR.
  - count=0 goes straight to DUMP_CR.
- DUMP_CR / DUMP_LF: emit 0x0D then 0x0A, same tx_full rule, then IDLE. The buffer is not modified.
- Latency:
  - rd_uart at cycle n gives PROC at n+1.
  - The first echo wr_uart is at n+2 when tx_full=0.
  - Throughput is at most one rx byte per 3 cycles with echo off.
- Display:
  - Registered.
  - disp byte i = buf[count-1-i] and disp_valid[i]=1 for i<count; otherwise the byte is 0 and the bit is 0.
  - Updated the cycle after count changes.
  - Cleared the cycle after a CR commit.
- busy = (state != IDLE).
- Widths:
  - count is LW bits and saturates at LINE_DEPTH; it never wraps.
  - idx is LW bits.

Decomposition:
- Shared package uart_term_pkg holds:
  - ASCII constants: BEL 0x07, BS 0x08, DEL 0x7F, CR 0x0D, LF 0x0A, SP 0x20, TILDE 0x7E.
  - FSM state encoding.
- One sub-module, term_line_buf:
  - LINE_DEPTH x DBIT register file with one write port and two read ports (dump index, display window).

Test Plan:
- Echo: echo_en=1; rx "A","B",CR. Expect wr_uart bytes 0x41, 0x42, 0x0D, 0x0A; line_valid once with line_len=2; disp_valid=0000 after the commit.
- Backspace: rx "XY",0x08. Expect echo 0x58, 0x59, 0x08, 0x20, 0x08; count=1; disp_bytes[7:0]=0x58; disp_valid=0001. A BS with count=0 produces no wr_uart.
- Overflow, LINE_DEPTH=16: rx 17 chars "a".."q". Expect the 17th echoed as 0x07 and overflow=1. CR then gives line_len=16 and overflow back to 0.
- Dump with backpressure:
  - Buffer "HI"; pulse dump_req with tx_full toggling 1/0 every cycle. Expect 0x48, 0x49, 0x0D, 0x0A, no duplicates, wr_uart only while tx_full=0.
  - A dump_req arriving in PROC is serviced before the next rx byte.
- Echo off / OTHER: echo_en=0; rx 0x01 then "Z". Expect no wr_uart, rd_uart pulses at least 3 cycles apart, count=1.
- Reset mid-dump: assert reset during DUMP after one byte. Expect no further wr_uart, count=0, and all outputs 0 the cycle after reset.
